// File: rtl/led_pkg.sv
// Shared constants, state encoding and one-hot helpers for the LED bank scheduler.
package led_pkg;

    localparam int unsigned N_LED = 4;
    localparam int unsigned N_REQ = 4;
    localparam int unsigned IDX_W = 2;
    localparam logic [N_LED-1:0] LED_OFF = 4'b1111;

    typedef enum logic {
        IDLE,
        SERVE
    } state_e;

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (oh[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    // Pattern nibble of the one-hot selected requester; zero when nothing is selected.
    function automatic logic [N_LED-1:0] pat_of(input logic [N_REQ*N_LED-1:0] pat,
                                                 input logic [N_REQ-1:0] oh);
        logic [N_LED-1:0] sel;
        sel = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (oh[i]) sel |= pat[i*N_LED +: N_LED];
        end
        return sel;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first unmasked requester at or after start_i, wrapping.
module rr_pick
    import led_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] start_i,
    input  logic [N_REQ-1:0] mask_i,
    output logic [N_REQ-1:0] pick_o,
    output logic             valid_o
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        pick_o  = '0;
        valid_o = 1'b0;
        idx     = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = start_i + IDX_W'(k);
            if (!valid_o && req_i[idx] && !mask_i[idx]) begin
                pick_o[idx] = 1'b1;
                valid_o     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_scheduler.sv
// Time-sliced round-robin owner of a 4-LED bank; every output comes straight from a flop.
module led_scheduler
    import led_pkg::*;
#(
    parameter int unsigned SLOT_CYCLES = 25_000_000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*N_LED-1:0] pat,
    output logic [N_REQ-1:0]       grant,
    output logic [N_LED-1:0]       led,
    output logic                   busy
);

    localparam int unsigned CW = $clog2(SLOT_CYCLES + 1);
    localparam logic [CW-1:0] SLOT_LOAD = CW'(SLOT_CYCLES - 1);

    state_e           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_LED-1:0] led_q, led_d;
    logic             busy_q, busy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0] last_q, last_d;

    logic [N_REQ-1:0] mask;
    logic [N_REQ-1:0] pick;
    logic             pick_valid;
    logic             arb;
    logic             released;

    // last_q always holds the current owner while serving, so last_q+1 is the
    // correct search start both from IDLE and at the end of a slot.
    rr_pick u_rr_pick (
        .req_i   (req),
        .start_i (last_q + IDX_W'(1)),
        .mask_i  (mask),
        .pick_o  (pick),
        .valid_o (pick_valid)
    );

    assign released = ((req & grant_q) == '0);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        led_d   = led_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        mask    = '0;
        arb     = 1'b0;

        case (state_q)
            IDLE: begin
                arb = 1'b1;
            end
            SERVE: begin
                if (released) begin
                    mask = grant_q;
                    arb  = 1'b1;
                end else if (cnt_q == '0) begin
                    arb = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    led_d = ~pat_of(pat, grant_q);
                end
            end
            default: arb = 1'b1;
        endcase

        if (arb) begin
            if (pick_valid) begin
                state_d = SERVE;
                grant_d = pick;
                led_d   = ~pat_of(pat, pick);
                busy_d  = 1'b1;
                cnt_d   = SLOT_LOAD;
                last_d  = onehot_to_idx(pick);
            end else begin
                state_d = IDLE;
                grant_d = '0;
                led_d   = LED_OFF;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            led_q   <= LED_OFF;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            last_q  <= IDX_W'(N_REQ - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign grant = grant_q;
    assign led   = led_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_led_scheduler.sv
// Directed and randomized checks of led_scheduler against a slot-level reference model.
module tb_led_scheduler;

    localparam int SLOT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req = '0;
    logic [15:0] pat = '0;
    logic [3:0]  grant;
    logic [3:0]  led;
    logic        busy;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: owner index (-1 when idle), last granted index, cycles served.
    int         m_owner;
    int         m_last;
    int         m_served;
    logic [3:0] e_grant;
    logic [3:0] e_led;
    logic       e_busy;

    led_scheduler #(.SLOT_CYCLES(SLOT)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .pat   (pat),
        .grant (grant),
        .led   (led),
        .busy  (busy)
    );

    always #20 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner  = -1;
        m_last   = 3;
        m_served = 0;
        e_grant  = 4'b0000;
        e_led    = 4'b1111;
        e_busy   = 1'b0;
    endtask

    task automatic model_arbitrate();
        int nxt;
        nxt = -1;
        for (int k = 1; k <= 4; k++) begin
            if (nxt < 0 && req[(m_last + k) % 4]) nxt = (m_last + k) % 4;
        end
        m_owner = nxt;
        if (nxt >= 0) begin
            m_last   = nxt;
            m_served = 0;
        end
    endtask

    task automatic model_edge();
        if (m_owner < 0) begin
            model_arbitrate();
        end else begin
            m_served++;
            if (!req[m_owner] || m_served == SLOT) model_arbitrate();
        end
        if (m_owner < 0) begin
            e_grant = 4'b0000;
            e_led   = 4'b1111;
            e_busy  = 1'b0;
        end else begin
            e_grant = 4'(1 << m_owner);
            e_led   = ~pat[4*m_owner +: 4];
            e_busy  = 1'b1;
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".grant"}, grant, e_grant);
        chk({tag, ".led"}, led, e_led);
        chk({tag, ".busy"}, {3'b000, busy}, {3'b000, e_busy});
        chk({tag, ".onehot"}, {3'b000, $onehot0(grant)}, 4'b0001);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    // Asserts reset away from any clock edge to observe the asynchronous clear.
    task automatic do_reset(input string tag);
        #5;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs(tag);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_outputs({tag, "_held"});
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        #1;
        check_outputs("por");
        @(negedge clk);
        rst = 1'b0;

        // Single requester, repeatedly re-granted
        req = 4'b0001;
        pat = 16'h0005;
        tick("single_first");
        chk("single_led", led, 4'b1010);
        repeat (10) tick("single_hold");

        // Full contention rotates with 4-cycle slots
        req = 4'b1111;
        pat = 16'h8421;
        repeat (24) tick("contend");

        // Early release hands over on the next edge
        do_reset("rst_a");
        req = 4'b0011;
        pat = 16'h00C3;
        tick("early_g0");
        chk("early_g0_const", grant, 4'b0001);
        tick("early_s1");
        tick("early_s2");
        req = 4'b0010;
        tick("early_handover");
        chk("early_g1_const", grant, 4'b0010);
        chk("early_led_const", led, 4'b0011);
        tick("early_after");

        // Idle return
        req = 4'b0000;
        tick("idle_return");
        tick("idle_stay");

        // Reset in the middle of a slot owned by requester 2
        req = 4'b0100;
        pat = 16'h0A00;
        tick("mid_g2");
        chk("mid_g2_const", grant, 4'b0100);
        tick("mid_s1");
        do_reset("rst_mid");
        req = 4'b1111;
        tick("post_rst_first");
        chk("post_rst_const", grant, 4'b0001);
        repeat (6) tick("post_rst_rot");

        // Live pattern change mid-slot
        do_reset("rst_b");
        req = 4'b0001;
        pat = 16'h0001;
        tick("live_g0");
        chk("live_led_a", led, 4'b1110);
        pat = 16'h0008;
        tick("live_follow");
        chk("live_led_b", led, 4'b0111);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) req = 4'($urandom);
            if ($urandom_range(0, 9) == 0) req = 4'b0000;
            pat = 16'($urandom);
            if ($urandom_range(0, 99) == 0) do_reset("rand_rst");
            tick("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
